// File: rtl/spi_hoarder_pkg.sv
// rtl/spi_hoarder_pkg.sv - shared FSM state type and attribute bit positions for spi_frame_hoarder
package spi_hoarder_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } hoarder_state_e;

    localparam int ATTR_VALID  = 0;
    localparam int ATTR_FRAME  = 1;
    localparam int ATTR_RX_OVF = 2;
    localparam int ATTR_TX_ERR = 3;

endpackage

// File: rtl/spi_word_shifter.sv
// rtl/spi_word_shifter.sv - assembles SPI bytes into words; byte order set by SPI_HOARDER_LSB_FIRST_EN
module spi_word_shifter #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      stb,
    input  logic [SPI_DATA_WIDTH-1:0] byte_in,
    output logic                      word_done,
    output logic [DATA_WIDTH-1:0]     word
);
    localparam int BPW = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);

    logic [BW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;

    // word is the register contents including the byte arriving this cycle
`ifdef SPI_HOARDER_LSB_FIRST_EN
    assign word = {byte_in, shreg[DATA_WIDTH-1:SPI_DATA_WIDTH]};
`else
    assign word = {shreg[DATA_WIDTH-SPI_DATA_WIDTH-1:0], byte_in};
`endif

    assign word_done = stb && !clear && (cnt == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (stb) begin
            shreg <= word;
            cnt   <= word_done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_frame_hoarder.sv
// rtl/spi_frame_hoarder.sv - SPI byte to word bridge with ping-pong rx banks and tx FIFO; option macro SPI_HOARDER_LSB_FIRST_EN
module spi_frame_hoarder
    import spi_hoarder_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int ATTR_WIDTH     = 4,
    parameter int FRAME_WORDS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      ready,
    input  logic [SPI_DATA_WIDTH-1:0] data_in_byte,
    output logic [SPI_DATA_WIDTH-1:0] data_out_byte,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      oe,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [ATTR_WIDTH-1:0]     attr_hoarder
);
    localparam int BPW = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PW  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int CW  = $clog2(FRAME_WORDS + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPW - 1);
    localparam logic [PW-1:0] LAST_WORD = PW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FRAME_WORDS);

    hoarder_state_e state_q, state_d;

    logic                  ready_q, byte_stb, active, rx_stb, tx_stb;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] bank [2][FRAME_WORDS];
    logic                  fill_sel, swap_pending;
    logic [PW-1:0]         rx_idx, rd_ptr;
    logic                  frame_avail, rd_valid, rx_ovf, tx_err, rd_fire;
    logic [DATA_WIDTH-1:0] fifo [FRAME_WORDS];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         level;
    logic [BW-1:0]         tx_idx;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head_word;

    assign byte_stb  = ready & ~ready_q;
    assign active    = (state_q == ACTIVE);
    assign rx_stb    = byte_stb & active;
    assign tx_stb    = byte_stb & active & ~frame_start;
    assign rd_fire   = oe & frame_avail;
    assign push      = wr && (level != FULL);
    assign pop       = tx_stb && (level != '0) && (tx_idx == LAST_BYTE);
    assign head_word = fifo[head];

    spi_word_shifter #(
        .DATA_WIDTH     (DATA_WIDTH),
        .SPI_DATA_WIDTH (SPI_DATA_WIDTH)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .stb       (rx_stb),
        .byte_in   (data_in_byte),
        .word_done (word_done),
        .word      (rx_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start) state_d = ACTIVE;
            ACTIVE:  if (frame_start) state_d = ACTIVE;
                     else if (swap_pending) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            fill_sel     <= 1'b0;
            swap_pending <= 1'b0;
            rx_idx       <= '0;
            rd_ptr       <= '0;
            frame_avail  <= 1'b0;
            rd_valid     <= 1'b0;
            rx_ovf       <= 1'b0;
            tx_err       <= 1'b0;
            data_out     <= '0;
            head         <= '0;
            tail         <= '0;
            level        <= '0;
            tx_idx       <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready;
            rd_valid <= rd_fire;

            // the read sees the pre-swap bank; the swap below then overrides rd_ptr
            if (rd_fire) begin
                data_out <= bank[~fill_sel][rd_ptr];
                if (rd_ptr == LAST_WORD) begin
                    rd_ptr      <= '0;
                    frame_avail <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end

            if (swap_pending) begin
                swap_pending <= 1'b0;
                fill_sel     <= ~fill_sel;
                rd_ptr       <= '0;
                frame_avail  <= 1'b1;
                if (frame_avail && !(rd_fire && rd_ptr == LAST_WORD)) rx_ovf <= 1'b1;
            end

            if (frame_start) begin
                rx_idx <= '0;
            end else if (word_done) begin
                if (rx_idx == LAST_WORD) begin
                    rx_idx       <= '0;
                    swap_pending <= 1'b1;
                end else begin
                    rx_idx <= rx_idx + 1'b1;
                end
            end

            if (push) tail <= (tail == LAST_WORD) ? '0 : tail + 1'b1;
            if (pop)  head <= (head == LAST_WORD) ? '0 : head + 1'b1;
            level <= level + CW'(push) - CW'(pop);

            if (frame_start) tx_idx <= '0;
            else if (tx_stb && level != '0) tx_idx <= (tx_idx == LAST_BYTE) ? '0 : tx_idx + 1'b1;

            if ((tx_stb && level == '0) || (wr && level == FULL)) tx_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && word_done) bank[fill_sel][rx_idx] <= rx_word;
        if (!rst && push) fifo[tail] <= data_in;
    end

    always_comb begin
        data_out_byte = '0;
        if (level != '0) begin
`ifdef SPI_HOARDER_LSB_FIRST_EN
            data_out_byte = head_word[int'(tx_idx) * SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
`else
            data_out_byte = head_word[(BPW - 1 - int'(tx_idx)) * SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
`endif
        end
    end

    always_comb begin
        attr_hoarder              = '0;
        attr_hoarder[ATTR_VALID]  = rd_valid;
        attr_hoarder[ATTR_FRAME]  = frame_avail;
        attr_hoarder[ATTR_RX_OVF] = rx_ovf;
        attr_hoarder[ATTR_TX_ERR] = tx_err;
    end

endmodule

// File: tb/tb_spi_frame_hoarder.sv
// tb/tb_spi_frame_hoarder.sv - queue-model checked bench for spi_frame_hoarder (32-bit words, 2-word frames)
module tb_spi_frame_hoarder;
    localparam int FW = 2;

`ifdef SPI_HOARDER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
    localparam logic [31:0] W0 = 32'h44332211, W1 = 32'h88776655, WY0 = 32'hCCBBAA99,
                            WY1 = 32'h10FFEEDD, WR = 32'h04030201, TX_ORDER = 32'hD4C3B2A1;
`else
    localparam bit LSB = 1'b0;
    localparam logic [31:0] W0 = 32'h11223344, W1 = 32'h55667788, WY0 = 32'h99AABBCC,
                            WY1 = 32'hDDEEFF10, WR = 32'h01020304, TX_ORDER = 32'hA1B2C3D4;
`endif

    logic        clk = 1'b0, rst = 1'b1, frame_start = 1'b0, ready = 1'b0, wr = 1'b0, oe = 1'b0;
    logic [7:0]  data_in_byte = '0;
    logic [31:0] data_in = '0;
    logic [7:0]  data_out_byte;
    logic [31:0] data_out;
    logic [3:0]  attr_hoarder;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spi_frame_hoarder #(
        .DATA_WIDTH(32), .SPI_DATA_WIDTH(8), .ATTR_WIDTH(4), .FRAME_WORDS(FW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .ready(ready),
        .data_in_byte(data_in_byte), .data_out_byte(data_out_byte),
        .wr(wr), .data_in(data_in), .oe(oe), .data_out(data_out),
        .attr_hoarder(attr_hoarder)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: byte/word/frame queues updated once per clock from the sampled inputs
    logic [7:0]  m_bytes[$];
    logic [31:0] m_words[$], m_full[$], m_readq[$], m_txq[$];
    bit          m_prev_ready = 0, m_active = 0, m_swap = 0, m_valid = 0, m_ovf = 0, m_txerr = 0;
    int          m_txidx = 0;
    logic [31:0] m_dout = '0;

    always @(posedge clk) begin : model
        bit stb, swapped;
        int lvl;
        logic [31:0] w;
        stb = ready && !m_prev_ready;
        m_prev_ready = ready;
        if (rst) begin
            m_bytes.delete(); m_words.delete(); m_full.delete(); m_readq.delete(); m_txq.delete();
            m_prev_ready = 0; m_active = 0; m_swap = 0; m_valid = 0; m_ovf = 0; m_txerr = 0;
            m_txidx = 0; m_dout = '0;
        end else begin
            swapped = 0;
            m_valid = 0;
            lvl = m_txq.size();
            if (oe && m_readq.size() > 0) begin
                m_dout = m_readq.pop_front();
                m_valid = 1;
            end
            if (m_swap) begin
                if (m_readq.size() > 0) m_ovf = 1;
                m_readq = m_full;
                m_swap = 0;
                swapped = 1;
            end
            if (frame_start) begin
                m_bytes.delete(); m_words.delete(); m_txidx = 0;
            end else if (m_active && stb) begin
                m_bytes.push_back(data_in_byte);
                if (m_bytes.size() == 4) begin
                    w = '0;
                    for (int i = 0; i < 4; i++)
                        w = LSB ? (w | (32'(m_bytes[i]) << (8 * i))) : ((w << 8) | 32'(m_bytes[i]));
                    m_words.push_back(w);
                    m_bytes.delete();
                    if (m_words.size() == FW) begin
                        m_full = m_words;
                        m_words.delete();
                        m_swap = 1;
                    end
                end
                if (lvl == 0) m_txerr = 1;
                else if (m_txidx == 3) begin m_txq.delete(0); m_txidx = 0; end
                else m_txidx++;
            end
            if (frame_start) m_active = 1;
            else if (swapped) m_active = 0;
            if (wr) begin
                if (lvl < FW) m_txq.push_back(data_in);
                else m_txerr = 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] t;
        logic [7:0]  eb;
        if (chk_en) begin
            eb = '0;
            if (m_txq.size() > 0) begin
                t  = LSB ? (m_txq[0] >> (8 * m_txidx)) : (m_txq[0] >> (8 * (3 - m_txidx)));
                eb = t[7:0];
            end
            chk("data_out", data_out, m_dout);
            chk("attr", 32'(attr_hoarder), {28'd0, m_txerr, m_ovf, m_readq.size() != 0, m_valid});
            chk("data_out_byte", 32'(data_out_byte), 32'(eb));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic pulse_fs();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); data_in_byte = b; ready = 1'b1;
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 8; i++) send_byte(8'((base + i) * 17));
    endtask

    task automatic do_read();
        @(negedge clk); oe = 1'b1;
        @(negedge clk); oe = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] w);
        @(negedge clk); wr = 1'b1; data_in = w;
        @(negedge clk); wr = 1'b0;
    endtask

    initial begin
        logic [31:0] seq;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_attr", 32'(attr_hoarder), 32'd0);
        chk("reset_byte", 32'(data_out_byte), 32'd0);
        rst = 1'b0;

        // full frame then two reads
        pulse_fs();
        send_frame(1);
        tick();
        chk("t1_frame", 32'(attr_hoarder[1]), 32'd1);
        do_read();
        chk("t1_word0", data_out, W0);
        chk("t1_valid0", 32'(attr_hoarder[0]), 32'd1);
        tick();
        chk("t1_valid_pulse", 32'(attr_hoarder[0]), 32'd0);
        do_read();
        chk("t1_word1", data_out, W1);
        chk("t1_frame_clr", 32'(attr_hoarder[1]), 32'd0);

        // transmit one word, then underrun
        do_reset();
        do_write(32'hA1B2C3D4);
        pulse_fs();
        seq = TX_ORDER;
        for (int i = 0; i < 4; i++) begin
            chk("t2_tx_byte", 32'(data_out_byte), 32'(seq[31 - 8 * i -: 8]));
            send_byte(8'($urandom));
        end
        chk("t2_empty_byte", 32'(data_out_byte), 32'd0);
        chk("t2_no_err", 32'(attr_hoarder[3]), 32'd0);
        send_byte(8'h5A);
        chk("t2_underrun", 32'(attr_hoarder[3]), 32'd1);

        // two frames without reads
        do_reset();
        pulse_fs(); send_frame(1);
        pulse_fs(); send_frame(9);
        tick();
        chk("t3_ovf", 32'(attr_hoarder[2]), 32'd1);
        do_read();
        chk("t3_word0", data_out, WY0);
        do_read();
        chk("t3_word1", data_out, WY1);

        // restart mid-word
        do_reset();
        pulse_fs();
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
        pulse_fs();
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
        tick();
        do_read();
        chk("t4_restart_word", data_out, WR);

        // read lands on the swap cycle
        do_reset();
        pulse_fs(); send_frame(1);
        pulse_fs(); send_frame(9);
        oe = 1'b1;
        @(negedge clk); oe = 1'b0;
        chk("t5_old_word", data_out, W0);
        chk("t5_valid", 32'(attr_hoarder[0]), 32'd1);
        chk("t5_frame", 32'(attr_hoarder[1]), 32'd1);
        chk("t5_ovf", 32'(attr_hoarder[2]), 32'd1);
        do_read();
        chk("t5_new_word0", data_out, WY0);

        // FIFO overfill
        do_reset();
        do_write(32'h10000001);
        do_write(32'h20000002);
        chk("t6_not_full_err", 32'(attr_hoarder[3]), 32'd0);
        do_write(32'h30000003);
        chk("t6_full_err", 32'(attr_hoarder[3]), 32'd1);
        pulse_fs();
        for (int i = 0; i < 9; i++) send_byte(8'($urandom));

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            rst          = ($urandom_range(0, 399) == 0);
            frame_start  = ($urandom_range(0, 59) == 0);
            ready        = 1'($urandom_range(0, 1));
            data_in_byte = 8'($urandom);
            wr           = ($urandom_range(0, 5) == 0);
            data_in      = $urandom;
            oe           = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        rst = 1'b0; frame_start = 1'b0; ready = 1'b0; wr = 1'b0; oe = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
